// File: rtl/sram_access_ctrl.sv
// One SRAM macro access per request: precharge, wordline/column select, then sense or write-drive.
// Strobes decode from the registered state so they stay glitch-free relative to clk.
module sram_access_ctrl #(
  parameter int ADDR_WIDTH       = 8,
  parameter int COL_ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int PRECHARGE_CYCLES = 2,
  parameter int SENSE_CYCLES     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [ADDR_WIDTH-COL_ADDR_WIDTH-1:0] row_addr,
  output logic                             row_en,
  output logic [COL_ADDR_WIDTH-1:0]        col_addr,
  output logic                             col_en,
  output logic                             precharge_en,
  output logic                             write_drv_en,
  output logic [DATA_WIDTH-1:0]            wdata_out,
  output logic                             sense_en,
  input  logic [DATA_WIDTH-1:0]            sense_data
);

  localparam int ROW_W   = ADDR_WIDTH - COL_ADDR_WIDTH;
  localparam int CNT_MAX = (PRECHARGE_CYCLES > SENSE_CYCLES) ? PRECHARGE_CYCLES : SENSE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRECHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEN_LOAD = CNT_W'(SENSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRECH  = 3'd1,
    ACCESS = 3'd2,
    SENSE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_ADDR_WIDTH-1:0] col_q, col_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    row_d        = row_q;
    col_d        = col_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    row_en       = 1'b0;
    col_en       = 1'b0;
    precharge_en = 1'b0;
    write_drv_en = 1'b0;
    sense_en     = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          state_d = PRECH;
          cnt_d   = PRE_LOAD;
          we_d    = req_we;
          row_d   = req_addr[ADDR_WIDTH-1:COL_ADDR_WIDTH];
          col_d   = req_addr[COL_ADDR_WIDTH-1:0];
          if (req_we) wdata_d = req_wdata;
        end
      end
      PRECH: begin
        precharge_en = 1'b1;
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACCESS: begin
        row_en       = 1'b1;
        col_en       = 1'b1;
        write_drv_en = we_q;
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = SENSE;
          cnt_d   = SEN_LOAD;
        end
      end
      SENSE: begin
        row_en   = 1'b1;
        col_en   = 1'b1;
        sense_en = 1'b1;
        // Capture on the edge that ends the final sense cycle.
        if (cnt_q == '0) begin
          state_d = RESP;
          rdata_d = sense_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign row_addr  = row_q;
  assign col_addr  = col_q;
  assign wdata_out = wdata_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: default timing instance plus a P=1/S=3 instance.
module tb_sram_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       req_valid, req_we, req_ready, rsp_valid;
  logic [7:0] req_addr, req_wdata, rsp_rdata, wdata_out, sense_data;
  logic [3:0] row_addr, col_addr;
  logic       row_en, col_en, precharge_en, write_drv_en, sense_en;

  logic       req_valid2, req_we2, req_ready2, rsp_valid2;
  logic [7:0] req_addr2, req_wdata2, rsp_rdata2, wdata_out2, sense_data2;
  logic [3:0] row_addr2, col_addr2;
  logic       row_en2, col_en2, precharge_en2, write_drv_en2, sense_en2;

  sram_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .row_addr(row_addr),
    .row_en(row_en), .col_addr(col_addr), .col_en(col_en),
    .precharge_en(precharge_en), .write_drv_en(write_drv_en),
    .wdata_out(wdata_out), .sense_en(sense_en), .sense_data(sense_data)
  );

  sram_access_ctrl #(.PRECHARGE_CYCLES(1), .SENSE_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .row_addr(row_addr2),
    .row_en(row_en2), .col_addr(col_addr2), .col_en(col_en2),
    .precharge_en(precharge_en2), .write_drv_en(write_drv_en2),
    .wdata_out(wdata_out2), .sense_en(sense_en2), .sense_data(sense_data2)
  );

  // {precharge_en, row_en, col_en, write_drv_en, sense_en, rsp_valid}
  logic [5:0] strb, strb2;
  assign strb  = {precharge_en, row_en, col_en, write_drv_en, sense_en, rsp_valid};
  assign strb2 = {precharge_en2, row_en2, col_en2, write_drv_en2, sense_en2, rsp_valid2};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Strobe invariants on every cycle for both instances.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("inv_prech_excl", 32'(precharge_en & (row_en | col_en | write_drv_en | sense_en)), 0);
      chk("inv_wd_se", 32'(write_drv_en & sense_en), 0);
      chk("inv2_prech_excl", 32'(precharge_en2 & (row_en2 | col_en2 | write_drv_en2 | sense_en2)), 0);
      chk("inv2_wd_se", 32'(write_drv_en2 & sense_en2), 0);
    end
  end

  int acc [0:3];
  int bound;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00; sense_data = 8'h00;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 8'h00; req_wdata2 = 8'h00; sense_data2 = 8'h00;

    // Reset
    tick(); tick();
    chk("rst_strb", 32'(strb), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_row", 32'(row_addr), 0);
    chk("rst_col", 32'(col_addr), 0);
    chk("rst_wdata", 32'(wdata_out), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    chk("rst2_all", 32'({strb2, req_ready2, row_addr2, col_addr2, wdata_out2, rsp_rdata2}), 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(req_ready), 1);

    // Read 0xA5, sense 0x3C; address disturbed after accept
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hA5; sense_data = 8'h3C;
    tick();
    req_valid = 1'b0; req_addr = 8'h00;
    chk("rd_t1_strb", 32'(strb), 'b100000);
    chk("rd_t1_ready", 32'(req_ready), 0);
    chk("rd_row", 32'(row_addr), 'hA);
    chk("rd_col", 32'(col_addr), 'h5);
    req_addr = 8'hFF;
    tick(); chk("rd_t2_strb", 32'(strb), 'b100000);
    req_addr = 8'h3C;
    tick(); chk("rd_t3_strb", 32'(strb), 'b011000);
    tick(); chk("rd_t4_strb", 32'(strb), 'b011010);
    tick();
    chk("rd_t5_strb", 32'(strb), 'b000001);
    chk("rd_t5_rdata", 32'(rsp_rdata), 'h3C);
    chk("rd_hold_addr", 32'({row_addr, col_addr}), 'hA5);
    tick();
    chk("rd_t6_strb", 32'(strb), 0);
    chk("rd_t6_ready", 32'(req_ready), 1);

    // Write 0xFF / 0x81; rsp_rdata must stay 0x3C
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hFF; req_wdata = 8'h81; sense_data = 8'h55;
    tick();
    req_valid = 1'b0; req_wdata = 8'h00;
    chk("wr_t1_strb", 32'(strb), 'b100000);
    tick(); chk("wr_t2_strb", 32'(strb), 'b100000);
    tick();
    chk("wr_t3_strb", 32'(strb), 'b011100);
    chk("wr_t3_wdata", 32'(wdata_out), 'h81);
    chk("wr_addr", 32'({row_addr, col_addr}), 'hFF);
    tick();
    chk("wr_t4_strb", 32'(strb), 'b000001);
    chk("wr_rdata_kept", 32'(rsp_rdata), 'h3C);
    tick();
    chk("wr_t5_ready", 32'(req_ready), 1);

    // Back-to-back: read 0x00, write 0x10, read 0x0F with req_valid held
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; sense_data = 8'h77;
    for (int k = 0; k < 4; k++) begin
      bound = 0;
      while (!req_ready && bound < 20) begin
        tick();
        bound++;
      end
      chk("b2b_timeout", 32'(bound < 20), 1);
      acc[k] = cyc;
      if (k < 3) begin
        tick();
        if (k == 0) begin req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'hC3; end
        if (k == 1) begin req_we = 1'b0; req_addr = 8'h0F; end
        if (k == 2) req_valid = 1'b0;
      end
    end
    chk("b2b_gap_rd", 32'(acc[1] - acc[0]), 6);
    chk("b2b_gap_wr", 32'(acc[2] - acc[1]), 5);
    chk("b2b_gap_rd2", 32'(acc[3] - acc[2]), 6);
    chk("b2b_last_addr", 32'({row_addr, col_addr}), 'h0F);
    chk("b2b_rdata", 32'(rsp_rdata), 'h77);
    chk("b2b_wdata", 32'(wdata_out), 'hC3);

    // Reset during SENSE aborts the read
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h33; sense_data = 8'h99;
    tick(); req_valid = 1'b0;
    tick(); tick(); tick();
    chk("abort_in_sense", 32'(strb), 'b011010);
    rst = 1'b1;
    #1;
    chk("abort_ready_low", 32'(req_ready), 0);
    tick();
    rst = 1'b0;
    chk("abort_strb", 32'(strb), 0);
    chk("abort_rdata", 32'(rsp_rdata), 0);
    chk("abort_row", 32'(row_addr), 0);
    tick();
    chk("abort_no_rsp", 32'(rsp_valid), 0);

    // Following read completes normally
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h5A; sense_data = 8'h24;
    tick(); req_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("post_abort_strb", 32'(strb), 'b000001);
    chk("post_abort_rdata", 32'(rsp_rdata), 'h24);
    chk("post_abort_addr", 32'({row_addr, col_addr}), 'h5A);

    // P=1, S=3 instance: read 0x42
    req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = 8'h42; sense_data2 = 8'h6B;
    tick(); req_valid2 = 1'b0;
    chk("sw_t1_strb", 32'(strb2), 'b100000);
    chk("sw_addr", 32'({row_addr2, col_addr2}), 'h42);
    tick(); chk("sw_t2_strb", 32'(strb2), 'b011000);
    tick(); chk("sw_t3_strb", 32'(strb2), 'b011010);
    tick(); chk("sw_t4_strb", 32'(strb2), 'b011010);
    tick(); chk("sw_t5_strb", 32'(strb2), 'b011010);
    chk("sw_t5_rdata_old", 32'(rsp_rdata2), 0);
    tick();
    chk("sw_t6_strb", 32'(strb2), 'b000001);
    chk("sw_t6_rdata", 32'(rsp_rdata2), 'h6B);
    tick();
    chk("sw_t7_ready", 32'(req_ready2), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
Sequences one SRAM macro access per request: precharge, then wordline and column select, then sense for reads or write-drive for writes. Splits the request address into a row address for the row decoder and a column address plus enable for column_decoder. Sits between the Tiny Tapeout user logic (single requester, valid/ready) and the bitcell array periphery.

Parameters:
ADDR_WIDTH, 8, total word address width; row = upper ADDR_WIDTH-COL_ADDR_WIDTH bits.
COL_ADDR_WIDTH, 4, column address width; drives column_decoder.addr (NUM_COLS = 2**COL_ADDR_WIDTH).
DATA_WIDTH, 8, read/write data width.
PRECHARGE_CYCLES, 2, cycles precharge_en is held per access; legal range ≥1.
SENSE_CYCLES, 1, cycles sense_en is held on reads; legal range ≥1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous and active-high.
req_valid  input  1  request present.
req_ready  output  1  controller can accept; high only in IDLE and not in reset.
req_we  input  1  1 = write, 0 = read; sampled on accept.
req_addr  input  ADDR_WIDTH  word address; sampled on accept.
req_wdata  input  DATA_WIDTH  write data; sampled on accept.
rsp_valid  output  1  one-cycle completion pulse for reads and writes.
rsp_rdata  output  DATA_WIDTH  read data; valid when rsp_valid follows a read, held until the next read completes.
row_addr  output  ADDR_WIDTH-COL_ADDR_WIDTH  latched row address.
row_en  output  1  wordline enable.
col_addr  output  COL_ADDR_WIDTH  latched column address to column_decoder.
col_en  output  1  column_decoder enable.
precharge_en  output  1  bitline precharge.
write_drv_en  output  1  write driver enable.
wdata_out  output  DATA_WIDTH  latched write data to the write drivers.
sense_en  output  1  sense amplifier enable.
sense_data  input  DATA_WIDTH  sense amplifier outputs.

Behaviour:
- Reset (rst=1 at an edge): state ← IDLE. All registered outputs ← 0: row_addr, col_addr, wdata_out, rsp_rdata, rsp_valid, and all strobes. req_ready=0 while rst is high. Reset aborts any access in progress. No rsp_valid is produced for an aborted access.
- req_ready = (state==IDLE) && !rst. Accept occurs when req_valid && req_ready at an edge. On accept, latch row_addr ← req_addr[ADDR_WIDTH-1:COL_ADDR_WIDTH], col_addr ← req_addr[COL_ADDR_WIDTH-1:0], wdata_out ← req_wdata (writes only), and the we flag.
- States and timing, with accept at cycle T:
  - PRECH: cycles T+1..T+P (P=PRECHARGE_CYCLES). precharge_en=1. Down-counter loaded with P-1 on accept.
  - ACCESS: 1 cycle. row_en=1, col_en=1, and write_drv_en=we. Next state is SENSE for a read, RESP for a write.
  - SENSE (reads only): S cycles (S=SENSE_CYCLES). row_en=1, col_en=1, sense_en=1. rsp_rdata ← sense_data at the edge ending the last SENSE cycle.
  - RESP: 1 cycle. rsp_valid=1, all strobes 0. Next state IDLE.
- Resulting latencies:
  - Read: rsp_valid in cycle T+P+S+2.
  - Write: rsp_valid in cycle T+P+2.
  - Next accept is possible in the cycle after RESP. Back-to-back read period is P+S+3 cycles.
- Strobes are decoded from the registered state, so they are glitch-free relative to clk.
- Invariants:
  - precharge_en is never high with row_en, col_en, write_drv_en or sense_en.
  - write_drv_en and sense_en are never both high.
  - Strobes in IDLE are all 0.
- Inputs are ignored outside IDLE; req_addr changes mid-access do not affect row_addr or col_addr.
- Writes leave rsp_rdata unchanged.
- Address boundaries need no special handling: all-zero and all-one addresses map directly to row 0/col 0 and row max/col max. There is no wrap logic.

Test Plan:
- Reset, then read: rst for 2 cycles → all outputs 0. Read at addr 0xA5 with defaults (P=2, S=1), sense_data=0x3C → row_addr=0xA, col_addr=0x5. precharge_en in T+1..T+2; row_en/col_en in T+3..T+4; sense_en in T+4; rsp_valid=1 and rsp_rdata=0x3C in T+5; req_ready=1 in T+6.
- Write: write addr 0xFF, wdata 0x81 → precharge_en in T+1..T+2; row_en/col_en/write_drv_en=1 with wdata_out=0x81 in T+3; rsp_valid in T+4; sense_en never high; rsp_rdata unchanged.
- Back-to-back traffic: req_valid held high for read 0x00, write 0x10, read 0x0F → accepts exactly 6, 5 and 6 cycles apart. req_ready is low during each access. Strobe invariants hold every cycle.
- Mid-access disturbance: req_addr toggles during the access → row_addr/col_addr unchanged. rst asserted in the SENSE cycle → next cycle all strobes 0 and rsp_rdata=0, no rsp_valid; a following read completes normally.
- Parameter sweep with PRECHARGE_CYCLES=1 and SENSE_CYCLES=3, read at 0x42 → precharge_en for 1 cycle, sense_en for 3 cycles, rsp_valid at T+6.
